load_store_unit: RTL and testbench

Memory-access stage directly downstream of the execute ALU. It takes the ALU's 32-bit result as the effective address, along with the rs2 store data and the instruction's funct3. It issues one word-aligned request on a simple req/ack data-memory port. For loads it aligns and sign/zero-extends the returned data; for stores it replicates the data and generates byte enables. While it works it reports Busy, and it signals completion with a one-cycle Done pulse plus an error code.

---
 rtl/load_store_unit.sv | 218 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: one word-aligned req/ack transaction per load/store,
// with load alignment/extension and store lane replication.
module load_store_unit #(
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic               MemWrite,
  input  logic [2:0]         Funct3,
  input  logic [D_WIDTH-1:0] ALUResult,
  input  logic [D_WIDTH-1:0] WriteData,
  output logic               Busy,
  output logic               Done,
  output logic [1:0]         Err,
  output logic [D_WIDTH-1:0] ReadData,
  output logic               MemReq,
  output logic               MemWe,
  output logic [D_WIDTH-1:0] MemAddr,
  output logic [D_WIDTH-1:0] MemWData,
  output logic [3:0]         MemByteEn,
  input  logic               MemAck,
  input  logic [D_WIDTH-1:0] MemRData
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [2:0]  f3_r, f3_s;
  logic [1:0]  off_r, off_s;
  logic        we_r, we_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic [3:0]  be_r, be_s;
  logic        req_r, req_s;
  logic        done_r, done_s;
  logic        busy_r, busy_s;
  logic [1:0]  err_r, err_s;
  logic [31:0] rdata_r, rdata_s;
  logic        illegal_s, misaligned_s;
  logic [3:0]  req_be_s;
  logic [31:0] req_wdata_s;

  // Select the addressed byte/half from the returned word and extend it.
  function automatic logic [31:0] ld_extend(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  ld_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_extend = {24'h000000, sh[7:0]};
      3'b101:  ld_extend = {16'h0000, sh[15:0]};
      default: ld_extend = sh;
    endcase
  endfunction

  // Request legality, alignment, byte lanes and replicated store data.
  always_comb begin
    illegal_s    = 1'b1;
    misaligned_s = 1'b0;
    req_be_s     = 4'b0000;
    req_wdata_s  = 32'h0000_0000;
    case (Funct3)
      3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
      3'b100, 3'b101:         illegal_s = MemWrite;
      default:                illegal_s = 1'b1;
    endcase
    case (Funct3[1:0])
      2'b00: begin
        req_be_s = 4'b0001 << ALUResult[1:0];
        if (MemWrite) req_wdata_s = {4{WriteData[7:0]}};
        else          req_wdata_s = 32'h0000_0000;
      end
      2'b01: begin
        misaligned_s = ALUResult[0];
        req_be_s     = 4'b0011 << ALUResult[1:0];
        if (MemWrite) req_wdata_s = {2{WriteData[15:0]}};
        else          req_wdata_s = 32'h0000_0000;
      end
      2'b10: begin
        misaligned_s = (ALUResult[1:0] != 2'b00);
        req_be_s     = 4'b1111;
        if (MemWrite) req_wdata_s = WriteData;
        else          req_wdata_s = 32'h0000_0000;
      end
      default: begin
        misaligned_s = 1'b0;
        req_be_s     = 4'b0000;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          if (illegal_s || misaligned_s) state_s = DONE;
          else                           state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (MemAck || (cnt_r == CNT_LIMIT)) state_s = DONE;
        else                                state_s = REQ;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and captured request.
  always_comb begin
    cnt_s   = cnt_r;
    f3_s    = f3_r;
    off_s   = off_r;
    we_s    = we_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    be_s    = be_r;
    req_s   = 1'b0;
    done_s  = 1'b0;
    err_s   = err_r;
    rdata_s = rdata_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          if (illegal_s) begin
            err_s  = 2'b10;
            done_s = 1'b1;
          end else if (misaligned_s) begin
            err_s  = 2'b01;
            done_s = 1'b1;
          end else begin
            f3_s    = Funct3;
            off_s   = ALUResult[1:0];
            we_s    = MemWrite;
            addr_s  = {ALUResult[31:2], 2'b00};
            wdata_s = req_wdata_s;
            be_s    = req_be_s;
            req_s   = 1'b1;
            cnt_s   = 8'd0;
          end
        end else begin
          req_s = 1'b0;
        end
      end
      REQ: begin
        if (MemAck) begin
          if (!we_r) rdata_s = ld_extend(f3_r, off_r, MemRData);
          else       rdata_s = rdata_r;
          err_s  = 2'b00;
          done_s = 1'b1;
        end else if (cnt_r == CNT_LIMIT) begin
          err_s  = 2'b11;
          done_s = 1'b1;
        end else begin
          req_s = 1'b1;
          cnt_s = cnt_r + 8'd1;
        end
      end
      DONE:    req_s = 1'b0;
      default: req_s = 1'b0;
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      f3_r    <= 3'b000;
      off_r   <= 2'b00;
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      be_r    <= 4'b0000;
      req_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 2'b00;
      rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      f3_r    <= f3_s;
      off_r   <= off_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      be_r    <= be_s;
      req_r   <= req_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      err_r   <= err_s;
      rdata_r <= rdata_s;
    end
  end

  assign Busy      = busy_r;
  assign Done      = done_r;
  assign Err       = err_r;
  assign ReadData  = rdata_r;
  assign MemReq    = req_r;
  assign MemWe     = we_r;
  assign MemAddr   = addr_r;
  assign MemWData  = wdata_r;
  assign MemByteEn = be_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed vectors.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n, Start, MemWrite, MemAck;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData, MemRData;
  logic        Busy, Done, MemReq, MemWe;
  logic [1:0]  Err;
  logic [31:0] ReadData, MemAddr, MemWData;
  logic [3:0]  MemByteEn;

  int vectors = 0;
  int errors  = 0;

  load_store_unit #(.D_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .Busy(Busy), .Done(Done), .Err(Err),
    .ReadData(ReadData), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemByteEn(MemByteEn), .MemAck(MemAck), .MemRData(MemRData)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
    Start = 1'b1; MemWrite = we; Funct3 = f3; ALUResult = addr; WriteData = wd;
    tick();
    Start = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_rd);
    start_op(1'b0, f3, addr, 32'h5555_5555);
    check({tag, "_req"}, MemReq, 32'd1);
    check({tag, "_we"}, MemWe, 32'd0);
    check({tag, "_addr"}, MemAddr, exp_addr);
    check({tag, "_be"}, MemByteEn, exp_be);
    check({tag, "_wdata"}, MemWData, 32'h0);
    MemAck = 1'b1; MemRData = rd;
    tick();
    MemAck = 1'b0;
    check({tag, "_done"}, Done, 32'd1);
    check({tag, "_rdata"}, ReadData, exp_rd);
    check({tag, "_err"}, Err, 32'd0);
    check({tag, "_reqdrop"}, MemReq, 32'd0);
    tick();
    check({tag, "_done1"}, Done, 32'd0);
    check({tag, "_idle"}, Busy, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd);
    start_op(1'b1, f3, addr, wd);
    check({tag, "_req"}, MemReq, 32'd1);
    check({tag, "_we"}, MemWe, 32'd1);
    check({tag, "_addr"}, MemAddr, exp_addr);
    check({tag, "_be"}, MemByteEn, exp_be);
    check({tag, "_wdata"}, MemWData, exp_wd);
    MemAck = 1'b1; MemRData = 32'h0F0F_0F0F;
    tick();
    MemAck = 1'b0;
    check({tag, "_done"}, Done, 32'd1);
    check({tag, "_err"}, Err, 32'd0);
    check({tag, "_rdata"}, ReadData, exp_rd);
    tick();
    check({tag, "_idle"}, Busy, 32'd0);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [1:0] exp_err,
                        input logic [31:0] exp_rd);
    start_op(we, f3, addr, 32'h1111_2222);
    check({tag, "_done"}, Done, 32'd1);
    check({tag, "_err"}, Err, {30'd0, exp_err});
    check({tag, "_noreq"}, MemReq, 32'd0);
    tick();
    check({tag, "_done1"}, Done, 32'd0);
    check({tag, "_idle"}, Busy, 32'd0);
    check({tag, "_errhold"}, Err, {30'd0, exp_err});
    check({tag, "_rdata"}, ReadData, exp_rd);
  endtask

  initial begin
    int nreq;
    int ncyc;
    rst_n = 1'b0; Start = 1'b0; MemWrite = 1'b0; MemAck = 1'b0; Funct3 = 3'b000;
    ALUResult = 32'h0; WriteData = 32'h0; MemRData = 32'h0;
    tick(); tick();
    check("rst_busy", Busy, 32'd0);
    check("rst_done", Done, 32'd0);
    check("rst_req", MemReq, 32'd0);
    check("rst_we", MemWe, 32'd0);
    check("rst_addr", MemAddr, 32'h0);
    check("rst_wdata", MemWData, 32'h0);
    check("rst_be", MemByteEn, 32'h0);
    check("rst_rdata", ReadData, 32'h0);
    check("rst_err", Err, 32'd0);
    rst_n = 1'b1;
    tick();

    do_load("lw",   3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb",   3'b000, 32'h0000_0103, 32'h8011_2233, 32'h0000_0100, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu",  3'b100, 32'h0000_0103, 32'h8011_2233, 32'h0000_0100, 4'b1000, 32'h0000_0080);
    do_load("lh",   3'b001, 32'h0000_0102, 32'h8011_2233, 32'h0000_0100, 4'b1100, 32'hFFFF_8011);
    do_load("lhu",  3'b101, 32'h0000_0102, 32'h8011_2233, 32'h0000_0100, 4'b1100, 32'h0000_8011);
    do_load("lb1",  3'b000, 32'h0000_0061, 32'h8011_2233, 32'h0000_0060, 4'b0010, 32'h0000_0022);

    do_store("sh", 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0000_0022);
    do_store("sb", 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0022);
    do_store("sw", 3'b010, 32'h0000_0300, 32'hCAFE_1234, 32'h0000_0300, 4'b1111, 32'hCAFE_1234, 32'h0000_0022);

    do_err("lw_mis",   1'b0, 3'b010, 32'h0000_0101, 2'b01, 32'h0000_0022);
    do_err("lh_mis",   1'b0, 3'b001, 32'h0000_0103, 2'b01, 32'h0000_0022);
    do_err("st_f100",  1'b1, 3'b100, 32'h0000_0100, 2'b10, 32'h0000_0022);
    do_err("ld_f011",  1'b0, 3'b011, 32'h0000_0100, 2'b10, 32'h0000_0022);
    do_err("st_prio",  1'b1, 3'b101, 32'h0000_0201, 2'b10, 32'h0000_0022);

    // No ack: MemReq must be high for exactly 16 cycles before the timeout Done.
    start_op(1'b0, 3'b010, 32'h0000_0400, 32'h0);
    nreq = 0; ncyc = 0;
    while (!Done && ncyc < 40) begin
      if (MemReq) nreq++;
      ncyc++;
      tick();
    end
    check("to_done", Done, 32'd1);
    check("to_reqcycles", nreq, 32'd16);
    check("to_err", Err, 32'd3);
    check("to_reqdrop", MemReq, 32'd0);
    check("to_rdata", ReadData, 32'h0000_0022);
    tick();
    check("to_idle", Busy, 32'd0);

    // Ack arriving on the 16th REQ cycle wins over the timeout.
    start_op(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    check("late_req", MemReq, 32'd1);
    check("late_nodone", Done, 32'd0);
    MemAck = 1'b1; MemRData = 32'hCAFE_F00D;
    tick();
    MemAck = 1'b0;
    check("late_done", Done, 32'd1);
    check("late_err", Err, 32'd0);
    check("late_rdata", ReadData, 32'hCAFE_F00D);
    tick();

    // Start during REQ is ignored; reset mid-operation clears everything with no Done.
    start_op(1'b0, 3'b010, 32'h0000_0600, 32'h0);
    tick();
    Start = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0700; WriteData = 32'h7777_7777;
    tick();
    Start = 1'b0;
    tick();
    check("ign_req", MemReq, 32'd1);
    check("ign_we", MemWe, 32'd0);
    check("ign_addr", MemAddr, 32'h0000_0600);
    check("ign_wdata", MemWData, 32'h0);
    rst_n = 1'b0;
    tick();
    check("mrst_req", MemReq, 32'd0);
    check("mrst_done", Done, 32'd0);
    check("mrst_busy", Busy, 32'd0);
    check("mrst_addr", MemAddr, 32'h0);
    check("mrst_be", MemByteEn, 32'h0);
    check("mrst_rdata", ReadData, 32'h0);
    check("mrst_err", Err, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_done", Done, 32'd0);
    check("post_req", MemReq, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
